// File: rtl/umi_mem_initiator_if.sv
// umi_mem_initiator_if: UMI host request/response channel bundle.
// Ports (signals):
//   req_valid/req_ready, req_cmd[CW], req_dstaddr/req_srcaddr[AW], req_data[DW]
//   resp_valid/resp_ready, resp_cmd[CW], resp_dstaddr/resp_srcaddr[AW], resp_data[DW]
// master: the initiator (drives requests, accepts responses); slave: the memory side.
interface umi_mem_initiator_if #(
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 256
);
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_cmd;
    logic [AW-1:0] req_dstaddr;
    logic [AW-1:0] req_srcaddr;
    logic [DW-1:0] req_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [CW-1:0] resp_cmd;
    logic [AW-1:0] resp_dstaddr;
    logic [AW-1:0] resp_srcaddr;
    logic [DW-1:0] resp_data;
    modport master (
        output req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data, resp_ready,
        input  req_ready, resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data
    );
    modport slave (
        input  req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data, resp_ready,
        output req_ready, resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data
    );
endinterface

// File: rtl/umi_mem_initiator.sv
// umi_mem_initiator: writes a seed+i pattern to count consecutive 8-byte words, reads them back and checks.
// Ports:
//   clk, reset (sync, active high)
//   start pulse; base_addr, count, seed, host_addr sampled on an accepted start
//   busy, done status; err_count (saturating), first_err_addr (valid when err_count != 0)
//   uhost: master side of the UMI request/response channel
module umi_mem_initiator #(
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [AW-1:0]       base_addr,
    input  logic [15:0]         count,
    input  logic [63:0]         seed,
    input  logic [AW-1:0]       host_addr,
    output logic                busy,
    output logic                done,
    output logic [15:0]         err_count,
    output logic [AW-1:0]       first_err_addr,
    umi_mem_initiator_if.master uhost
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;
    state_t        state, state_n;
    logic [15:0]   idx, idx_n, cnt_q;
    logic [AW-1:0] base_q, host_q, addr_i, addr_n, host_n;
    logic [63:0]   seed_q, pat_i, pat_n;
    logic          take, req_hs, resp_hs, last, bad, req_n, wr_n;
    logic          unused_ok;

    assign take    = start && (state == IDLE || state == DONE);
    assign req_hs  = uhost.req_valid && uhost.req_ready;
    assign resp_hs = uhost.resp_valid && uhost.resp_ready;
    assign last    = (idx + 16'd1) >= cnt_q;
    assign addr_i  = base_q + AW'({idx, 3'b000});
    assign pat_i   = seed_q + 64'(idx);
    // Next-cycle request fields use the live inputs on the start edge, before they are sampled.
    assign addr_n  = (take ? base_addr : base_q) + AW'({idx_n, 3'b000});
    assign pat_n   = (take ? seed : seed_q) + 64'(idx_n);
    assign host_n  = take ? host_addr : host_q;
    assign req_n   = state_n == WR_REQ || state_n == RD_REQ;
    assign wr_n    = state_n == WR_REQ;
    // A failing response counts once even when both opcode and data are wrong.
    assign bad     = state == WR_RESP ? uhost.resp_cmd[4:0] != 5'h04
                   : (uhost.resp_cmd[4:0] != 5'h02 || uhost.resp_data[63:0] != pat_i);
    assign unused_ok = ^{uhost.resp_cmd, uhost.resp_dstaddr, uhost.resp_srcaddr, uhost.resp_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE, DONE: if (start) begin
                state_n = count == 16'd0 ? DONE : WR_REQ;
                idx_n   = '0;
            end
            WR_REQ:  if (req_hs) state_n = WR_RESP;
            WR_RESP: if (resp_hs) begin
                state_n = last ? RD_REQ : WR_REQ;
                idx_n   = last ? 16'd0 : idx + 16'd1;
            end
            RD_REQ:  if (req_hs) state_n = RD_RESP;
            RD_RESP: if (resp_hs) begin
                state_n = last ? DONE : RD_REQ;
                idx_n   = last ? idx : idx + 16'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy             = state == WR_REQ || state == WR_RESP || state == RD_REQ || state == RD_RESP;
        done             = state == DONE;
        uhost.resp_ready = state == WR_RESP || state == RD_RESP;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q            <= '0;
            host_q            <= '0;
            seed_q            <= '0;
            cnt_q             <= '0;
            err_count         <= '0;
            first_err_addr    <= '0;
            uhost.req_valid   <= 1'b0;
            uhost.req_cmd     <= '0;
            uhost.req_dstaddr <= '0;
            uhost.req_srcaddr <= '0;
            uhost.req_data    <= '0;
        end else begin
            if (take) begin
                base_q         <= base_addr;
                host_q         <= host_addr;
                seed_q         <= seed;
                cnt_q          <= count;
                err_count      <= '0;
                first_err_addr <= '0;
            end else if (resp_hs && bad) begin
                err_count <= err_count == 16'hFFFF ? err_count : err_count + 16'd1;
                if (err_count == 16'd0) first_err_addr <= addr_i;
            end
            // Fields are recomputed from the held index while stalled, so they stay stable.
            uhost.req_valid   <= req_n;
            uhost.req_cmd     <= req_n ? CW'({1'b1, 14'd0, 3'd3, wr_n ? 5'h03 : 5'h01}) : '0;
            uhost.req_dstaddr <= req_n ? addr_n : '0;
            uhost.req_srcaddr <= req_n ? host_n : '0;
            uhost.req_data    <= wr_n ? DW'(pat_n) : '0;
        end
    end
endmodule

// File: tb/tb_umi_mem_initiator.sv
// tb_umi_mem_initiator: directed runs against a transaction-level memory model with optional faults.
module tb_umi_mem_initiator;
    localparam int CW = 32;
    localparam int AW = 64;
    localparam int DW = 256;

    typedef struct {
        logic [4:0]  op;
        logic [63:0] addr;
        logic [63:0] data;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [15:0]   count = '0;
    logic [63:0]   seed = '0;
    logic [AW-1:0] host_addr = '0;
    logic          busy, done;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;
    int            total = 0;
    int            bad = 0;
    int            cyc;
    logic [63:0]   mem [logic [63:0]];

    umi_mem_initiator_if #(.CW(CW), .AW(AW), .DW(DW)) uhost ();

    umi_mem_initiator #(.CW(CW), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .seed(seed), .host_addr(host_addr), .busy(busy), .done(done), .err_count(err_count),
        .first_err_addr(first_err_addr), .uhost(uhost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [63:0] b, input logic [15:0] n, input logic [63:0] s,
                       input logic [63:0] h, input int crd, input int bwr, input int brd,
                       input bit rnd, input bit poke, input bit rst_rd, output int cycles);
        txn_t        q[$];
        txn_t        t;
        bit          pend, stall, fin, abort;
        int          dly, widx, ridx, exp_err, wr_err;
        logic [63:0] exp_first, rdat;
        logic [31:0] rcmd, pcmd;
        logic [63:0] pdst, psrc;
        logic [255:0] pdat;
        for (int i = 0; i < int'(n); i++) q.push_back('{5'h03, b + 64'(i) * 64'd8, s + 64'(i)});
        for (int i = 0; i < int'(n); i++) q.push_back('{5'h01, b + 64'(i) * 64'd8, 64'd0});
        exp_err = 0;
        exp_first = '0;
        for (int i = 0; i < int'(n); i++)
            if (i == bwr) begin
                if (exp_err == 0) exp_first = b + 64'(i) * 64'd8;
                exp_err++;
            end
        wr_err = exp_err;
        for (int i = 0; i < int'(n); i++)
            if (i == crd || i == brd) begin
                if (exp_err == 0) exp_first = b + 64'(i) * 64'd8;
                exp_err++;
            end
        mem.delete();
        pend = 0; stall = 0; fin = 0; abort = 0; dly = 0; widx = 0; ridx = 0;
        rcmd = '0; rdat = '0; pcmd = '0; pdst = '0; psrc = '0; pdat = '0;
        @(negedge clk);
        base_addr = b; count = n; seed = s; host_addr = h; start = 1'b1;
        cycles = 0;
        while (cycles < 3000 && !fin) begin
            @(negedge clk);
            cycles++;
            start = poke && cycles == 5;
            base_addr = {$urandom, $urandom};
            count = 16'($urandom);
            seed = {$urandom, $urandom};
            host_addr = {$urandom, $urandom};
            if (done) begin
                fin = 1;
                break;
            end
            chk("busy", busy, 1);
            chk("resp_ready", uhost.resp_ready, pend);
            if (stall) begin
                chk("stall_valid", uhost.req_valid, 1);
                chk("stall_cmd", uhost.req_cmd, pcmd);
                chk("stall_dst", uhost.req_dstaddr, pdst);
                chk("stall_src", uhost.req_srcaddr, psrc);
                chk("stall_data", uhost.req_data, pdat);
            end
            if (pend) begin
                if (dly > 0) begin
                    dly--;
                    uhost.resp_valid = 1'b0;
                end else begin
                    uhost.resp_valid = 1'b1;
                    uhost.resp_cmd = rcmd;
                    uhost.resp_data = DW'(rdat);
                    uhost.resp_dstaddr = h;
                    uhost.resp_srcaddr = {$urandom, $urandom};
                    if (uhost.resp_ready) pend = 0;
                end
            end else begin
                uhost.resp_valid = rnd ? 1'($urandom) : 1'b0;
                uhost.resp_cmd = $urandom;
                uhost.resp_data = {8{$urandom}};
            end
            if (rst_rd && uhost.req_valid && uhost.req_cmd[4:0] == 5'h01) begin
                chk("pre_reset_err", err_count, wr_err);
                reset = 1'b1;
                uhost.req_ready = 1'b0;
                uhost.resp_valid = 1'b0;
                @(negedge clk);
                chk("rst_valid", uhost.req_valid, 0);
                chk("rst_cmd", uhost.req_cmd, 0);
                chk("rst_dst", uhost.req_dstaddr, 0);
                chk("rst_src", uhost.req_srcaddr, 0);
                chk("rst_data", uhost.req_data, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_err", err_count, 0);
                chk("rst_first", first_err_addr, 0);
                chk("rst_resp_ready", uhost.resp_ready, 0);
                reset = 1'b0;
                abort = 1;
                break;
            end
            if (uhost.req_valid) begin
                chk("one_outstanding", pend, 0);
                if (q.size() == 0) chk("extra_req", uhost.req_valid, 0);
                else begin
                    t = q[0];
                    chk("req_cmd", uhost.req_cmd, {9'd0, 1'b1, 14'd0, 3'd3, t.op});
                    chk("req_dst", uhost.req_dstaddr, t.addr);
                    chk("req_src", uhost.req_srcaddr, h);
                    chk("req_data", uhost.req_data, DW'(t.data));
                end
                uhost.req_ready = rnd ? 1'($urandom) : 1'b1;
                if (uhost.req_ready && q.size() > 0) begin
                    t = q.pop_front();
                    pend = 1;
                    dly = rnd ? int'($urandom_range(0, 3)) : 0;
                    if (t.op == 5'h03) begin
                        mem[t.addr] = t.data;
                        rcmd = ($urandom & 32'hFFFF_FFE0) | (widx == bwr ? 32'h02 : 32'h04);
                        rdat = {$urandom, $urandom};
                        widx++;
                    end else begin
                        rdat = mem.exists(t.addr) ? mem[t.addr] : 64'd0;
                        if (ridx == crd) rdat = rdat ^ 64'd1;
                        rcmd = ($urandom & 32'hFFFF_FFE0) | (ridx == brd ? 32'h04 : 32'h02);
                        ridx++;
                    end
                end
                stall = !uhost.req_ready;
                pcmd = uhost.req_cmd;
                pdst = uhost.req_dstaddr;
                psrc = uhost.req_srcaddr;
                pdat = uhost.req_data;
            end else begin
                uhost.req_ready = rnd ? 1'($urandom) : 1'b0;
                stall = 0;
            end
        end
        start = 1'b0;
        uhost.req_ready = 1'b0;
        uhost.resp_valid = 1'b0;
        if (!abort) begin
            chk("done", done, 1);
            chk("busy_end", busy, 0);
            chk("req_valid_end", uhost.req_valid, 0);
            chk("err_count", err_count, exp_err);
            chk("first_err_addr", first_err_addr, exp_first);
            chk("txns_left", q.size(), 0);
        end
    endtask

    initial begin
        uhost.req_ready = 1'b0;
        uhost.resp_valid = 1'b0;
        uhost.resp_cmd = '0;
        uhost.resp_dstaddr = '0;
        uhost.resp_srcaddr = '0;
        uhost.resp_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err_count, 0);
        chk("reset_first", first_err_addr, 0);
        chk("reset_valid", uhost.req_valid, 0);
        chk("reset_cmd", uhost.req_cmd, 0);
        chk("reset_dst", uhost.req_dstaddr, 0);
        chk("reset_data", uhost.req_data, 0);
        chk("reset_resp_ready", uhost.resp_ready, 0);
        reset = 1'b0;

        run(64'h1000, 16'd4, 64'hA5A5_0000_0000_0000, 64'hBEEF, -1, -1, -1, 0, 0, 0, cyc);
        chk("basic_cycles", cyc, 17);
        repeat (3) @(negedge clk);
        chk("done_held", done, 1);

        run({$urandom, $urandom}, 16'd16, {$urandom, $urandom}, {$urandom, $urandom},
            -1, -1, -1, 1, 1, 0, cyc);

        run(64'h2000, 16'd4, {$urandom, $urandom}, 64'h77, 2, -1, -1, 1, 0, 0, cyc);
        chk("corrupt_first", first_err_addr, 64'h2010);

        run(64'h0, 16'd4, {$urandom, $urandom}, 64'h55, 3, 1, -1, 0, 0, 0, cyc);
        chk("badop_count", err_count, 2);
        chk("badop_first", first_err_addr, 64'h8);

        run(64'h3000, 16'd3, {$urandom, $urandom}, 64'h9, 1, -1, 1, 1, 0, 0, cyc);
        chk("double_fault_count", err_count, 1);

        run(64'h5000, 16'd0, 64'h1, 64'h2, -1, -1, -1, 0, 0, 0, cyc);
        chk("zero_cycles", cyc, 1);

        run(64'hFFFF_FFFF_FFFF_FFF8, 16'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, -1, -1, -1, 0, 0, 0, cyc);
        chk("wrap_cycles", cyc, 9);
        chk("wrap_mem", mem.exists(64'h0), 1);

        run(64'h4000, 16'd3, {$urandom, $urandom}, 64'h4, -1, 0, -1, 0, 0, 1, cyc);
        repeat (2) @(negedge clk);
        chk("post_reset_idle", busy, 0);

        run({$urandom, $urandom}, 16'd5, {$urandom, $urandom}, {$urandom, $urandom},
            -1, -1, -1, 1, 0, 0, cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
